// File: rtl/nasti_stream_writer_if.sv
// ----------------------------------------------------------------------------
// Interfaces used by nasti_stream_writer.
//
// nasti_stream_channel : NASTI stream (AXI4-Stream style) beat channel.
//    master drives t_valid/t_data/t_strb/t_keep/t_last/t_id/t_dest/t_user,
//    slave drives t_ready.
// nasti_channel        : NASTI memory port, write direction (AW, W, B).
//    master drives the AW and W payloads plus b_ready, slave drives
//    aw_ready, w_ready and the B response. The read channels are not
//    carried because the writer never reads.
// ----------------------------------------------------------------------------
interface nasti_stream_channel #(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1
);
   logic                    t_valid;
   logic                    t_ready;
   logic [DATA_WIDTH-1:0]   t_data;
   logic [DATA_WIDTH/8-1:0] t_strb;
   logic [DATA_WIDTH/8-1:0] t_keep;
   logic                    t_last;
   logic [ID_WIDTH-1:0]     t_id;
   logic [DEST_WIDTH-1:0]   t_dest;
   logic [USER_WIDTH-1:0]   t_user;

   modport master (
      output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
      input  t_ready
   );
   modport slave (
      input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
      output t_ready
   );
endinterface

interface nasti_channel #(
   parameter int ID_WIDTH   = 5,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1
);
   // write address
   logic                    aw_valid;
   logic                    aw_ready;
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    aw_lock;
   logic [3:0]              aw_cache;
   logic [2:0]              aw_prot;
   // write data
   logic                    w_valid;
   logic                    w_ready;
   logic [ID_WIDTH-1:0]     w_id;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic [USER_WIDTH-1:0]   w_user;
   // write response
   logic                    b_valid;
   logic                    b_ready;
   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
             aw_cache, aw_prot,
      input  aw_ready,
      output w_valid, w_id, w_data, w_strb, w_last, w_user,
      input  w_ready,
      input  b_valid, b_id, b_resp,
      output b_ready
   );
   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
             aw_cache, aw_prot,
      output aw_ready,
      input  w_valid, w_id, w_data, w_strb, w_last, w_user,
      output w_ready,
      output b_valid, b_id, b_resp,
      input  b_ready
   );
endinterface

// File: rtl/nasti_stream_writer.sv
// ----------------------------------------------------------------------------
// nasti_stream_writer
//
// Stream-to-memory mover. A request (w_dst byte address, w_len byte count)
// is split into NASTI INCR write bursts of at most MAX_BURST_LENGTH beats.
// Stream beats are passed straight through to the W channel while a burst is
// open; one burst is outstanding at a time. Any B response with b_resp[1]
// set raises the sticky w_error for the current request, without aborting.
//
// Ports
//    aclk, aresetn : clock, asynchronous active-low reset
//    src           : stream input (only t_ready is driven here)
//    dest          : memory write port (AW, W, B)
//    w_dst, w_len  : request address / length in bytes, beat aligned
//    w_valid       : request strobe, taken when w_valid && w_ready
//    w_ready       : high while idle
//    w_error       : sticky error of the last request
// ----------------------------------------------------------------------------
module nasti_stream_writer #(
   parameter int ADDR_WIDTH       = 64,
   parameter int DATA_WIDTH       = 64,
   parameter int MAX_BURST_LENGTH = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   nasti_stream_channel.slave    src,
   nasti_channel.master          dest,
   input  logic [ADDR_WIDTH-1:0] w_dst,
   input  logic [ADDR_WIDTH-1:0] w_len,
   input  logic                  w_valid,
   output logic                  w_ready,
   output logic                  w_error
);
   localparam int DATA_BYTE_CNT = DATA_WIDTH / 8;
   localparam int ADDR_SHIFT    = $clog2(DATA_BYTE_CNT);
   localparam int CNT_WIDTH     = ADDR_WIDTH - ADDR_SHIFT;

   localparam logic [CNT_WIDTH-1:0]  MAX_BEATS   = CNT_WIDTH'(MAX_BURST_LENGTH);
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(MAX_BURST_LENGTH) << ADDR_SHIFT;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~(ADDR_WIDTH'(DATA_BYTE_CNT - 1));

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

   state_e                state_q,     state_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;       // address of the next burst
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;  // beats not yet assigned to a burst
   logic [ADDR_WIDTH-1:0] aw_addr_q,   aw_addr_d;
   logic [7:0]            aw_len_q,    aw_len_d;
   logic                  aw_valid_q,  aw_valid_d;
   logic [CNT_WIDTH-1:0]  beat_cnt_q,  beat_cnt_d;
   logic                  w_ready_q,   w_ready_d;
   logic                  w_error_q,   w_error_d;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [CNT_WIDTH-1:0]  req_beats;
   logic                  load;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [CNT_WIDTH-1:0]  load_rem;
   logic                  in_w;
   logic                  w_beat;
   logic                  last_beat;

   // Hardware ignores misaligned low bits rather than faulting.
   assign req_addr  = w_dst & ALIGN_MASK;
   assign req_beats = w_len[ADDR_WIDTH-1:ADDR_SHIFT];

   assign in_w      = (state_q == S_W);
   assign w_beat    = in_w && src.t_valid && dest.w_ready;
   assign last_beat = (beat_cnt_q == CNT_WIDTH'(aw_len_q));

   always_comb begin
      // NOTE: every _d starts at its held value so no branch can infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      aw_addr_d   = aw_addr_q;
      aw_len_d    = aw_len_q;
      aw_valid_d  = aw_valid_q;
      beat_cnt_d  = beat_cnt_q;
      w_ready_d   = w_ready_q;
      w_error_d   = w_error_q;
      load        = 1'b0;
      load_addr   = addr_q;
      load_rem    = remaining_q;

      case (state_q)
         S_IDLE: begin
            if (w_valid) begin
               addr_d      = req_addr;
               remaining_d = req_beats;
               w_error_d   = 1'b0;
               // A zero-beat request is acknowledged but produces no traffic.
               if (req_beats != '0) begin
                  w_ready_d = 1'b0;
                  state_d   = S_AW;
                  load      = 1'b1;
                  load_addr = req_addr;
                  load_rem  = req_beats;
               end
            end
         end
         S_AW: begin
            if (dest.aw_ready) begin
               aw_valid_d = 1'b0;
               state_d    = S_W;
            end
         end
         S_W: begin
            if (w_beat) begin
               beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
               if (last_beat) state_d = S_B;
            end
         end
         S_B: begin
            if (dest.b_valid) begin
               w_error_d = w_error_q | dest.b_resp[1];
               if (remaining_q == '0) begin
                  state_d   = S_IDLE;
                  w_ready_d = 1'b1;
               end else begin
                  state_d = S_AW;
                  load    = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Carve the next burst off the remaining beats.
      if (load) begin
         aw_addr_d  = load_addr;
         aw_valid_d = 1'b1;
         beat_cnt_d = '0;
         if (load_rem > MAX_BEATS) begin
            aw_len_d    = 8'(MAX_BURST_LENGTH - 1);
            remaining_d = load_rem - MAX_BEATS;
            addr_d      = load_addr + BURST_BYTES;
         end else begin
            aw_len_d    = 8'(load_rem - CNT_WIDTH'(1));
            remaining_d = '0;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         aw_addr_q   <= '0;
         aw_len_q    <= '0;
         aw_valid_q  <= 1'b0;
         beat_cnt_q  <= '0;
         w_ready_q   <= 1'b1;
         w_error_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge _d values.
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         aw_addr_q   <= aw_addr_d;
         aw_len_q    <= aw_len_d;
         aw_valid_q  <= aw_valid_d;
         beat_cnt_q  <= beat_cnt_d;
         w_ready_q   <= w_ready_d;
         w_error_q   <= w_error_d;
      end
   end

   // Write address channel: registered payload, fixed attributes.
   assign dest.aw_valid = aw_valid_q;
   assign dest.aw_addr  = aw_addr_q;
   assign dest.aw_len   = aw_len_q;
   assign dest.aw_id    = '0;
   assign dest.aw_size  = 3'(ADDR_SHIFT);
   assign dest.aw_burst = 2'b01;
   assign dest.aw_lock  = 1'b0;
   assign dest.aw_cache = '0;
   assign dest.aw_prot  = '0;

   // Write data: zero-latency pass-through of the stream, gated to W state.
   assign dest.w_valid  = in_w && src.t_valid;
   assign dest.w_data   = src.t_data;
   assign dest.w_strb   = src.t_strb & src.t_keep;
   assign dest.w_last   = in_w && last_beat;
   assign dest.w_id     = '0;
   assign dest.w_user   = '0;
   assign src.t_ready   = in_w && dest.w_ready;

   assign dest.b_ready  = (state_q == S_B);

   assign w_ready = w_ready_q;
   assign w_error = w_error_q;

   // Stream framing and response ID carry no meaning here; length rules.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, src.t_last, src.t_id, src.t_dest, src.t_user,
                            dest.b_id, dest.b_resp[0]};

`ifndef SYNTHESIS
   a_req_aligned : assert property (@(posedge aclk) disable iff (!aresetn)
      !(state_q == S_IDLE && w_valid) ||
      (w_dst[ADDR_SHIFT-1:0] == '0 && w_len[ADDR_SHIFT-1:0] == '0))
      else $warning("misaligned w_dst/w_len at acceptance, low bits masked");
`endif

endmodule

// File: tb/tb_nasti_stream_writer.sv
module tb_nasti_stream_writer;
   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int MAXB = 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [AW-1:0] w_dst = '0;
   logic [AW-1:0] w_len = '0;
   logic          w_valid = 1'b0;
   logic          w_ready;
   logic          w_error;

   nasti_stream_channel #(.DATA_WIDTH(DW)) s_if ();
   nasti_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) d_if ();

   nasti_stream_writer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LENGTH(MAXB)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .src(s_if), .dest(d_if),
      .w_dst(w_dst), .w_len(w_len), .w_valid(w_valid),
      .w_ready(w_ready), .w_error(w_error)
   );

   always #5 aclk = ~aclk;

   typedef struct { logic [63:0] addr; logic [7:0] len; } burst_t;
   typedef struct { logic [63:0] data; logic [7:0] strb; logic [7:0] keep; } beat_t;
   typedef enum { PH_IDLE, PH_ADDR, PH_DATA, PH_RESP } phase_e;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: expected burst list, stream source, memory image.
   burst_t      bq[$];
   burst_t      aw_seen[$];
   beat_t       src_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] mem [logic [63:0]];
   phase_e      phase = PH_IDLE;
   bit          busy = 0, exp_err = 0, req_pending = 0, tv_hold = 0, spurious = 0;
   int          beat_idx = 0, b_idx = 0, err_target = -1;
   int          beats_written = 0, dup_cnt = 0;
   int          p_t = 100, p_w = 100, p_aw = 100, p_b = 100;
   logic [63:0] req_dst = '0, req_len = '0;
   logic [7:0]  last_strb = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      w_valid = 0; s_if.t_valid = 0; s_if.t_data = '0; s_if.t_strb = '0; s_if.t_keep = '0;
      s_if.t_last = 0; s_if.t_id = '0; s_if.t_dest = '0; s_if.t_user = '0;
      d_if.aw_ready = 0; d_if.w_ready = 0; d_if.b_valid = 0; d_if.b_resp = '0; d_if.b_id = '0;
   endtask

   task automatic model_reset();
      busy = 0; phase = PH_IDLE; exp_err = 0; req_pending = 0; tv_hold = 0;
      bq.delete(); src_q.delete();
   endtask

   // Expected bursts straight from the splitting rule.
   task automatic build_bursts(input logic [63:0] dst, input logic [63:0] len);
      logic [63:0] a = dst & ~64'h7;
      logic [63:0] rem = len >> 3;
      logic [63:0] n;
      bq.delete();
      while (rem != 0) begin
         n = (rem > MAXB) ? 64'(MAXB) : rem;
         bq.push_back('{addr: a, len: 8'(n - 1)});
         a   = a + n * 8;
         rem = rem - n;
      end
   endtask

   task automatic drive();
      d_if.aw_ready = ($urandom_range(99) < p_aw);
      d_if.w_ready  = ($urandom_range(99) < p_w);
      d_if.b_valid  = ($urandom_range(99) < p_b);
      d_if.b_resp   = (b_idx == err_target) ? 2'b10 : 2'b00;
      d_if.b_id     = '0;
      if (src_q.size() > 0 && (tv_hold || $urandom_range(99) < p_t)) begin
         s_if.t_valid = 1; s_if.t_data = src_q[0].data;
         s_if.t_strb = src_q[0].strb; s_if.t_keep = src_q[0].keep;
      end else begin
         s_if.t_valid = 0; s_if.t_data = {$urandom, $urandom};
         s_if.t_strb = 8'($urandom); s_if.t_keep = 8'($urandom);
      end
      s_if.t_last = 1'($urandom); s_if.t_id = 1'($urandom);
      s_if.t_dest = 1'($urandom); s_if.t_user = 1'($urandom);
      if (req_pending) begin
         w_valid = 1; w_dst = req_dst; w_len = req_len;
      end else if (busy && spurious && $urandom_range(3) == 0) begin
         w_valid = 1; w_dst = {$urandom, $urandom} & ~64'h3F; w_len = 64'h40;
      end else begin
         w_valid = 0;
      end
   endtask

   task automatic compare();
      check("w_ready", w_ready, !busy);
      check("w_error", w_error, exp_err);
      check("aw_valid", d_if.aw_valid, phase == PH_ADDR);
      check("b_ready", d_if.b_ready, phase == PH_RESP);
      check("w_valid", d_if.w_valid, phase == PH_DATA && s_if.t_valid);
      check("t_ready", s_if.t_ready, phase == PH_DATA && d_if.w_ready);
      if (phase == PH_ADDR) begin
         check("aw_addr", d_if.aw_addr, bq[0].addr);
         check("aw_len", d_if.aw_len, bq[0].len);
         check("aw_size", d_if.aw_size, 3'd3);
         check("aw_burst", d_if.aw_burst, 2'b01);
         check("aw_attr", {d_if.aw_id, d_if.aw_lock, d_if.aw_cache, d_if.aw_prot}, '0);
      end
      if (phase == PH_DATA) begin
         check("w_last", d_if.w_last, beat_idx == int'(bq[0].len));
         check("w_data", d_if.w_data, s_if.t_data);
         check("w_strb", d_if.w_strb, s_if.t_strb & s_if.t_keep);
         check("w_id_user", {d_if.w_id, d_if.w_user}, '0);
      end
   endtask

   // Predict what the coming edge does, from the bench's own view of the bus.
   task automatic advance();
      bit popped = 0;
      logic [63:0] a;
      if (d_if.aw_valid && d_if.aw_ready)
         aw_seen.push_back('{addr: d_if.aw_addr, len: d_if.aw_len});
      case (phase)
         PH_IDLE: if (w_valid) begin
            exp_err = 0; req_pending = 0;
            build_bursts(w_dst, w_len);
            if (bq.size() > 0) begin busy = 1; phase = PH_ADDR; b_idx = 0; end
         end
         PH_ADDR: if (d_if.aw_ready) begin phase = PH_DATA; beat_idx = 0; end
         PH_DATA: if (s_if.t_valid && d_if.w_ready) begin
            a = bq[0].addr + 64'(beat_idx) * 8;
            if (mem.exists(a)) dup_cnt++;
            mem[a] = d_if.w_data;
            last_strb = d_if.w_strb;
            beats_written++;
            void'(src_q.pop_front());
            popped = 1;
            if (beat_idx == int'(bq[0].len)) phase = PH_RESP;
            else beat_idx++;
         end
         PH_RESP: if (d_if.b_valid) begin
            exp_err = exp_err | d_if.b_resp[1];
            void'(bq.pop_front());
            b_idx++;
            if (bq.size() == 0) begin busy = 0; phase = PH_IDLE; end
            else phase = PH_ADDR;
         end
      endcase
      tv_hold = s_if.t_valid && !popped;
   endtask

   task automatic cycle();
      @(posedge aclk); #1;
      drive();
      @(negedge aclk);
      compare();
      advance();
   endtask

   task automatic start_request(input logic [63:0] dst, input logic [63:0] len,
                                input int err, input int smode);
      int nb = int'(len >> 3);
      beat_t b;
      exp_q.delete(); mem.delete(); aw_seen.delete();
      beats_written = 0; dup_cnt = 0;
      for (int i = 0; i < nb; i++) begin
         b.data = {$urandom, $urandom};
         case (smode)
            1:       begin b.strb = 8'h0F; b.keep = 8'hFF; end
            2:       begin b.strb = 8'($urandom); b.keep = 8'($urandom); end
            default: begin b.strb = 8'hFF; b.keep = 8'hFF; end
         endcase
         src_q.push_back(b);
         exp_q.push_back(b.data);
      end
      req_dst = dst; req_len = len; err_target = err; req_pending = 1;
   endtask

   task automatic finish_request(input string tag);
      int cyc = 0;
      logic [63:0] base = req_dst & ~64'h7;
      logic [63:0] a;
      while ((req_pending || busy) && cyc < 5000) begin cycle(); cyc++; end
      check({tag, " in budget"}, cyc < 5000, 1);
      check({tag, " beats"}, beats_written, exp_q.size());
      check({tag, " dup"}, dup_cnt, 0);
      check({tag, " stream left"}, src_q.size(), 0);
      foreach (exp_q[i]) begin
         a = base + 64'(i) * 8;
         check({tag, " mem"}, mem.exists(a) ? mem[a] : 64'hx, exp_q[i]);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      repeat (2) @(posedge aclk);
      #1;
      check("rst w_ready", w_ready, 1);
      check("rst w_error", w_error, 0);
      check("rst aw_valid", d_if.aw_valid, 0);
      check("rst aw_addr", d_if.aw_addr, 0);
      check("rst aw_len", d_if.aw_len, 0);
      check("rst w_valid", d_if.w_valid, 0);
      check("rst b_ready", d_if.b_ready, 0);
      check("rst t_ready", s_if.t_ready, 0);
      @(negedge aclk);
      aresetn = 1;

      // Single full burst.
      start_request(64'h1000, 64'h40, -1, 0);
      finish_request("single");
      check("single aw count", aw_seen.size(), 1);
      check("single aw addr", aw_seen[0].addr, 64'h1000);
      check("single aw len", aw_seen[0].len, 7);

      // 17 beats -> 8 + 8 + 1.
      start_request(64'h1000, 64'h88, -1, 0);
      finish_request("17beat");
      check("17beat aw count", aw_seen.size(), 3);
      check("17beat aw0 addr", aw_seen[0].addr, 64'h1000);
      check("17beat aw1 addr", aw_seen[1].addr, 64'h1040);
      check("17beat aw2 addr", aw_seen[2].addr, 64'h1080);
      check("17beat aw0 len", aw_seen[0].len, 7);
      check("17beat aw1 len", aw_seen[1].len, 7);
      check("17beat aw2 len", aw_seen[2].len, 0);
      check("17beat total", beats_written, 17);

      // Random stalls on every channel, random strobes, ignored requests while busy.
      spurious = 1;
      for (int k = 0; k < 4; k++) begin
         p_t  = $urandom_range(30, 90);
         p_w  = $urandom_range(30, 90);
         p_aw = $urandom_range(30, 90);
         p_b  = $urandom_range(30, 90);
         start_request(64'h2000 + 64'(k) * 64'h1000,
                       (k < 2) ? 64'h200 : 64'($urandom_range(1, 64)) * 8, -1, 2);
         finish_request("random");
      end
      spurious = 0;
      p_t = 100; p_w = 100; p_aw = 100; p_b = 100;

      // Error on the second of three bursts.
      start_request(64'h3000, 64'hC0, 1, 0);
      finish_request("error");
      check("error aw count", aw_seen.size(), 3);
      check("error sticky", w_error, 1);
      start_request(64'h4000, 64'h40, -1, 0);
      finish_request("after error");
      check("error cleared", w_error, 0);

      // Zero length: acknowledged, no bus traffic.
      start_request(64'h5000, 64'h0, -1, 0);
      finish_request("zero");
      repeat (3) cycle();
      check("zero aw count", aw_seen.size(), 0);
      check("zero w_ready", w_ready, 1);

      // Misaligned destination is masked.
      start_request(64'h1004, 64'h40, -1, 0);
      finish_request("misaligned");
      check("misaligned aw addr", aw_seen[0].addr, 64'h1000);

      // Strobe is the AND of t_strb and t_keep.
      start_request(64'h1000, 64'h40, -1, 1);
      finish_request("strobe");
      check("strobe value", last_strb, 8'h0F);

      // Asynchronous reset in the middle of the second burst.
      start_request(64'h7000, 64'h200, 0, 0);
      repeat (16) cycle();
      check("pre-reset w_error", w_error, 1);
      check("pre-reset t_ready or w_valid busy", w_ready, 0);
      #1;
      aresetn = 0;
      #1;
      check("mid rst w_ready", w_ready, 1);
      check("mid rst w_error", w_error, 0);
      check("mid rst aw_valid", d_if.aw_valid, 0);
      check("mid rst w_valid", d_if.w_valid, 0);
      check("mid rst b_ready", d_if.b_ready, 0);
      check("mid rst t_ready", s_if.t_ready, 0);
      model_reset();
      idle_inputs();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1;

      start_request(64'h6000, 64'h40, -1, 0);
      finish_request("recovery");
      check("recovery aw addr", aw_seen[0].addr, 64'h6000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
